pc_ir_unit: RTL and testbench

- Datapath register stage between the multi-cycle control FSM and memory/ALU.
- Holds PC, instruction register (IR), memory data register (MDR) and ALUOut.
- Resolves branch-taken from ALU flags and the FSM's BranchType.
- Drives the memory address mux and feeds the 7-bit control field (IR[6:0]) back to the FSM; also keeps instruction-fetch and taken-branch counters.

---
 rtl/pc_ir_unit.sv | 147 ++++++++++++++
 tb/tb_pc_ir_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// pc_ir_unit: datapath register stage of the multi-cycle CPU.
// Holds PC, IR, MDR and ALUOut, resolves the branch-taken decision from the
// ALU flags, drives the memory address mux and counts fetches and taken
// branches. PC arithmetic is performed entirely by the ALU.
module pc_ir_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int               CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             pc_write,
  input  logic             pc_src,
  input  logic             branch,
  input  logic [1:0]       branch_type,
  input  logic             ir_write,
  input  logic             iod,
  input  logic             mem_r,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic [6:0]       control_field,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] alu_out,
  output logic             branch_taken,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Branch condition selected by branch_type. Signed compares rely on the
  // ALU sign bit only, so they are valid while the difference fits WIDTH.
  function automatic logic branch_cond(input logic [1:0] bt,
                                       input logic       zero,
                                       input logic       neg);
    logic c;
    case (bt)
      2'b00:   c = zero;    // beq
      2'b01:   c = ~zero;   // bne
      2'b10:   c = neg;     // blt
      2'b11:   c = ~neg;    // bge
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] ir_r;
  logic [WIDTH-1:0] mdr_r;
  logic [WIDTH-1:0] alu_out_r;
  logic [CNT_W-1:0] fetch_count_r;
  logic [CNT_W-1:0] taken_count_r;

  logic             cond_s;
  logic             taken_s;
  logic [WIDTH-1:0] pc_next_s;
  logic [WIDTH-1:0] mem_addr_s;

  // Branch resolution and next-PC selection.
  always_comb begin
    cond_s    = branch_cond(branch_type, alu_zero, alu_neg);
    taken_s   = branch & pc_write & cond_s;
    pc_next_s = pc_r;
    if (pc_write) begin
      if (branch) begin
        if (cond_s) begin
          pc_next_s = alu_out_r;
        end else begin
          pc_next_s = pc_r;
        end
      end else begin
        pc_next_s = pc_src ? alu_out_r : alu_result;
      end
    end else begin
      pc_next_s = pc_r;
    end
  end

  // Memory address mux: instruction fetch from PC, data access from ALUOut.
  always_comb begin
    mem_addr_s = pc_r;
    if (iod) begin
      mem_addr_s = alu_out_r;
    end else begin
      mem_addr_s = pc_r;
    end
  end

  // Architectural registers; IR captures data addressed by the old PC on a
  // fetch edge while PC advances on that same edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc_r      <= RESET_PC;
      ir_r      <= {WIDTH{1'b0}};
      mdr_r     <= {WIDTH{1'b0}};
      alu_out_r <= {WIDTH{1'b0}};
    end else begin
      pc_r      <= pc_next_s;
      alu_out_r <= alu_result;
      if (ir_write) begin
        ir_r <= mem_rdata;
      end else begin
        ir_r <= ir_r;
      end
      if (mem_r) begin
        mdr_r <= mem_rdata;
      end else begin
        mdr_r <= mdr_r;
      end
    end
  end

  // Fetch and taken-branch counters; both wrap silently.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_count_r <= {CNT_W{1'b0}};
      taken_count_r <= {CNT_W{1'b0}};
    end else begin
      if (ir_write) begin
        fetch_count_r <= fetch_count_r + CNT_ONE;
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if (taken_s) begin
        taken_count_r <= taken_count_r + CNT_ONE;
      end else begin
        taken_count_r <= taken_count_r;
      end
    end
  end

  assign mem_addr      = mem_addr_s;
  assign pc            = pc_r;
  assign ir            = ir_r;
  assign control_field = ir_r[6:0];
  assign mdr           = mdr_r;
  assign alu_out       = alu_out_r;
  assign branch_taken  = taken_s;
  assign fetch_count   = fetch_count_r;
  assign taken_count   = taken_count_r;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Scoreboard bench for pc_ir_unit: stimulus pushes expected register state
// per edge, a monitor pops and compares after each rising edge. A second
// instance with 4-bit counters shares all inputs to exercise wrap-around.
module tb_pc_ir_unit;

  logic        CLK;
  logic        Reset;
  logic        pc_write, pc_src, branch, ir_write, iod, mem_r;
  logic [1:0]  branch_type;
  logic [15:0] mem_rdata, alu_result;
  logic        alu_zero, alu_neg;

  logic [15:0] mem_addr, pc, ir, mdr, alu_out, fetch_count, taken_count;
  logic [6:0]  control_field;
  logic        branch_taken;

  logic [15:0] mem_addr4, pc4, ir4, mdr4, alu_out4;
  logic [6:0]  control_field4;
  logic        branch_taken4;
  logic [3:0]  fetch_count4, taken_count4;

  pc_ir_unit dut (
    .CLK(CLK), .Reset(Reset), .pc_write(pc_write), .pc_src(pc_src),
    .branch(branch), .branch_type(branch_type), .ir_write(ir_write),
    .iod(iod), .mem_r(mem_r), .mem_rdata(mem_rdata), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_addr(mem_addr), .pc(pc),
    .ir(ir), .control_field(control_field), .mdr(mdr), .alu_out(alu_out),
    .branch_taken(branch_taken), .fetch_count(fetch_count),
    .taken_count(taken_count)
  );

  pc_ir_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .Reset(Reset), .pc_write(pc_write), .pc_src(pc_src),
    .branch(branch), .branch_type(branch_type), .ir_write(ir_write),
    .iod(iod), .mem_r(mem_r), .mem_rdata(mem_rdata), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .mem_addr(mem_addr4), .pc(pc4),
    .ir(ir4), .control_field(control_field4), .mdr(mdr4), .alu_out(alu_out4),
    .branch_taken(branch_taken4), .fetch_count(fetch_count4),
    .taken_count(taken_count4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] pc, ir, mdr, ao;
    int          fc, tc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural state, counters kept as unbounded ints.
  logic [15:0] m_pc, m_ir, m_mdr, m_ao;
  int          m_fc, m_tc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 16'h0000; m_mdr = 16'h0000; m_ao = 16'h0000;
    m_fc = 0; m_tc = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_ir"}, ir, 32'h0);
    check({tag, "_mdr"}, mdr, 32'h0);
    check({tag, "_alu_out"}, alu_out, 32'h0);
    check({tag, "_fc"}, fetch_count, 32'h0);
    check({tag, "_tc"}, taken_count, 32'h0);
    check({tag, "_fc4"}, fetch_count4, 32'h0);
    check({tag, "_tc4"}, taken_count4, 32'h0);
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic drive(input logic pw, input logic ps, input logic br,
                       input logic [1:0] bt, input logic iw, input logic io,
                       input logic mr, input logic [15:0] rd,
                       input logic [15:0] ar, input logic z, input logic n);
    exp_t        e;
    logic        cond, tk;
    logic [15:0] npc;
    pc_write = pw; pc_src = ps; branch = br; branch_type = bt;
    ir_write = iw; iod = io; mem_r = mr; mem_rdata = rd;
    alu_result = ar; alu_zero = z; alu_neg = n;
    #1;
    // Flag to compare: bit1 picks sign vs zero, bit0 inverts it.
    cond = (bt[1] ? n : z) ^ bt[0];
    tk   = br && pw && cond;
    check("mem_addr", mem_addr, io ? m_ao : m_pc);
    check("branch_taken", branch_taken, tk);
    npc = m_pc;
    if (pw && !br) npc = ps ? m_ao : ar;
    if (tk)        npc = m_ao;
    m_pc = npc;
    m_ao = ar;
    if (iw) m_ir = rd;
    if (mr) m_mdr = rd;
    if (iw) m_fc++;
    if (tk) m_tc++;
    e.pc = m_pc; e.ir = m_ir; e.mdr = m_mdr; e.ao = m_ao;
    e.fc = m_fc; e.tc = m_tc;
    exp_q.push_back(e);
    @(negedge CLK);
  endtask

  // Monitor: compare registered outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("ir", ir, e.ir);
        check("control_field", control_field, e.ir[6:0]);
        check("mdr", mdr, e.mdr);
        check("alu_out", alu_out, e.ao);
        check("fetch_count", fetch_count, e.fc[15:0]);
        check("taken_count", taken_count, e.tc[15:0]);
        check("fetch_count4", fetch_count4, e.fc[3:0]);
        check("taken_count4", taken_count4, e.tc[3:0]);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    pc_write = 1'b1; pc_src = 1'b0; branch = 1'b0; branch_type = 2'b00;
    ir_write = 1'b0; iod = 1'b0; mem_r = 1'b0; mem_rdata = 16'h0000;
    alu_result = 16'h1234; alu_zero = 1'b0; alu_neg = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    // Reset held with pc_write active: nothing may update.
    check_reset_state("reset_hold");
    Reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0);

    // Fetch: set PC to 5, then fetch with PC+1 from the ALU.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 16'h00A8, 16'h0006, 1'b0, 1'b0);
    check("fetch_cf_direct", control_field, 32'h28);

    // beq taken, then beq not taken.
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0040, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0077, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0050, 1'b0, 1'b0);
    // blt taken, bge not taken, bne taken.
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0090, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00B0, 1'b0, 1'b0);
    // Branch qualifier without pc_write must not move PC nor count.
    drive(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00C0, 1'b1, 1'b0);

    // Load path: ALUOut=0100, then read via iod, then hold MDR.
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0200, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h0300, 1'b0, 1'b0);
    check("mdr_hold_direct", mdr, 32'hBEEF);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom()), 16'($urandom()),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset asserted between edges.
    #2;
    Reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    check("async_reset_mem_addr", mem_addr, 32'h0);
    @(negedge CLK);
    check_reset_state("async_reset_held");
    Reset = 1'b0;
    model_reset();

    // Exactly 16 fetches and 16 taken branches wrap the 4-bit counters.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'($urandom()),
            16'($urandom()), 1'b1, 1'b0);
    end
    check("wrap_fc4", fetch_count4, 32'h0);
    check("wrap_tc4", taken_count4, 32'h0);
    check("wrap_fc16", fetch_count, 32'd16);
    check("wrap_tc16", taken_count, 32'd16);

    @(posedge CLK);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
